// File: rtl/turn_sequencer_pkg.sv
// Shared turn-code constants and sequencer state encoding, imported by the
// sequencer and by the line follower.
package turn_sequencer_pkg;

  typedef logic [1:0] turn_t;

  localparam turn_t TURN_STRAIGHT = 2'd0;
  localparam turn_t TURN_RIGHT    = 2'd1;
  localparam turn_t TURN_UTURN    = 2'd2;
  localparam turn_t TURN_LEFT     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_RUN,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/turn_sequencer_if.sv
// Turn-list load channel from the path planner (master) to the sequencer (slave).
interface turn_sequencer_if;
  import turn_sequencer_pkg::*;

  logic  load_valid;
  turn_t load_turn;
  logic  load_last;
  logic  load_ready;

  modport master (output load_valid, output load_turn, output load_last, input  load_ready);
  modport slave  (input  load_valid, input  load_turn, input  load_last, output load_ready);
endinterface

// File: rtl/turn_sequencer_mem.sv
// DEPTH x 2-bit turn list: one synchronous write port, one combinational read
// port, contents not reset.
module turn_mem
  import turn_sequencer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5
) (
  input  logic             clk_3125KHz,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  turn_t            wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output turn_t            rd_data
);

  turn_t mem [DEPTH];

  always_ff @(posedge clk_3125KHz) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/turn_sequencer.sv
// Path-execution block: loads a list of turn codes, then steps through it on
// each node_changed pulse from the line follower.
module turn_sequencer
  import turn_sequencer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5
) (
  input  logic               clk_3125KHz,
  input  logic               reset,
  input  logic               clear,
  turn_sequencer_if.slave    load,
  input  logic               start,
  input  logic               node_changed,
  output turn_t              turn_flag,
  output logic               end_path,
  output logic               busy,
  output logic [PTR_W:0]     path_len,
  output logic [PTR_W:0]     node_count,
  output logic               overflow
);

  localparam logic [PTR_W:0] FULL_LEN = (PTR_W+1)'(DEPTH);

  seq_state_t       state, state_d;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_d, rd_addr;
  turn_t            turn_flag_d, rd_data;
  logic             end_path_d, busy_d, overflow_d, mem_we, load_ready_w;
  logic [PTR_W:0]   path_len_d, node_count_d;

  assign load_ready_w    = (state == ST_IDLE) && (path_len < FULL_LEN);
  assign load.load_ready = load_ready_w;

  // Write address is the low bits of path_len; it only wraps once full, when no write occurs.
  turn_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk_3125KHz (clk_3125KHz),
    .we          (mem_we),
    .wr_addr     (path_len[PTR_W-1:0]),
    .wr_data     (load.load_turn),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always_comb begin
    state_d      = state;
    rd_ptr_d     = rd_ptr;
    turn_flag_d  = turn_flag;
    end_path_d   = end_path;
    busy_d       = busy;
    path_len_d   = path_len;
    node_count_d = node_count;
    overflow_d   = overflow;
    mem_we       = 1'b0;
    rd_addr      = '0;

    if (load.load_valid && !load_ready_w) overflow_d = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (load.load_valid && load_ready_w) begin
          mem_we     = 1'b1;
          path_len_d = path_len + 1'b1;
          if (load.load_last || path_len_d == FULL_LEN) state_d = ST_READY;
        end
      end
      ST_READY, ST_DONE: begin
        if (start) begin
          rd_ptr_d     = '0;
          node_count_d = '0;
          turn_flag_d  = rd_data;
          busy_d       = 1'b1;
          end_path_d   = 1'b0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        // Look one entry ahead so the next code is ready on the advancing edge.
        rd_addr = rd_ptr + 1'b1;
        if (node_changed) begin
          node_count_d = node_count + 1'b1;
          if ({1'b0, rd_ptr} == path_len - 1'b1) begin
            turn_flag_d = TURN_STRAIGHT;
            end_path_d  = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_DONE;
          end else begin
            rd_ptr_d    = rd_ptr + 1'b1;
            turn_flag_d = rd_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d      = ST_IDLE;
      rd_ptr_d     = '0;
      turn_flag_d  = TURN_STRAIGHT;
      end_path_d   = 1'b0;
      busy_d       = 1'b0;
      path_len_d   = '0;
      node_count_d = '0;
      overflow_d   = 1'b0;
      mem_we       = 1'b0;
    end
  end

  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      turn_flag  <= TURN_STRAIGHT;
      end_path   <= 1'b0;
      busy       <= 1'b0;
      path_len   <= '0;
      node_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      rd_ptr     <= rd_ptr_d;
      turn_flag  <= turn_flag_d;
      end_path   <= end_path_d;
      busy       <= busy_d;
      path_len   <= path_len_d;
      node_count <= node_count_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_turn_sequencer;
  import turn_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic reset, clear, start, node_changed;
  logic [1:0] turn_flag;
  logic end_path, busy, overflow;
  logic [PTR_W:0] path_len, node_count;

  turn_sequencer_if lif ();

  turn_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_3125KHz  (clk),
    .reset        (reset),
    .clear        (clear),
    .load         (lif),
    .start        (start),
    .node_changed (node_changed),
    .turn_flag    (turn_flag),
    .end_path     (end_path),
    .busy         (busy),
    .path_len     (path_len),
    .node_count   (node_count),
    .overflow     (overflow)
  );

  always #160 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the loaded list as a queue plus a few phase flags.
  logic [1:0] m_list[$];
  bit m_loading = 1, m_running = 0, m_done = 0, m_ovf = 0;
  int m_idx = 0, m_nodes = 0;

  always @(posedge clk) begin
    bit rdy;
    rdy = m_loading && (m_list.size() < DEPTH);
    if (reset || clear) begin
      m_list.delete();
      m_loading = 1; m_running = 0; m_done = 0; m_ovf = 0;
      m_idx = 0; m_nodes = 0;
    end else begin
      if (lif.load_valid && !rdy) m_ovf = 1;
      if (m_loading) begin
        if (lif.load_valid && rdy) begin
          m_list.push_back(lif.load_turn);
          if (lif.load_last || m_list.size() == DEPTH) m_loading = 0;
        end
      end else if (!m_running) begin
        if (start) begin
          m_running = 1; m_done = 0; m_idx = 0; m_nodes = 0;
        end
      end else if (node_changed) begin
        m_nodes++;
        if (m_idx == m_list.size() - 1) begin
          m_running = 0; m_done = 1;
        end else m_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("turn_flag",  int'(turn_flag),  m_running ? int'(m_list[m_idx]) : 0);
      chk("end_path",   int'(end_path),   int'(m_done));
      chk("busy",       int'(busy),       int'(m_running));
      chk("path_len",   int'(path_len),   m_list.size());
      chk("node_count", int'(node_count), m_nodes);
      chk("overflow",   int'(overflow),   int'(m_ovf));
      chk("load_ready", int'(lif.load_ready), int'(m_loading && m_list.size() < DEPTH));
    end
  end

  task automatic cyc(input bit lv, input logic [1:0] lt, input bit ll,
                     input bit st, input bit nc, input bit cl, input bit rs);
    lif.load_valid = lv; lif.load_turn = lt; lif.load_last = ll;
    start = st; node_changed = nc; clear = cl; reset = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 2'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic ld(input logic [1:0] t, input bit last);
    cyc(1, t, last, 0, 0, 0, 0);
  endtask

  task automatic node();
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
  endtask

  task automatic go();
    cyc(0, 2'd0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 2'd0, 0, 0, 0, 0, 1);
    cyc(0, 2'd0, 0, 0, 0, 0, 1);
    chk_en = 1;
    chk("rst_load_ready", int'(lif.load_ready), 1);
    chk("rst_path_len", int'(path_len), 0);
    chk("rst_turn_flag", int'(turn_flag), 0);

    // Node pulses while IDLE are ignored.
    node(); node();
    chk("idle_nc_count", int'(node_count), 0);
    chk("idle_nc_flag", int'(turn_flag), 0);

    // Basic list 1,3,0,2.
    ld(TURN_RIGHT, 0); ld(TURN_LEFT, 0); ld(TURN_STRAIGHT, 0); ld(TURN_UTURN, 1);
    chk("t1_path_len", int'(path_len), 4);
    chk("t1_load_ready", int'(lif.load_ready), 0);
    node();
    chk("ready_nc_count", int'(node_count), 0);
    go();
    chk("t1_flag0", int'(turn_flag), 1);
    chk("t1_busy", int'(busy), 1);
    node(); chk("t1_flag1", int'(turn_flag), 3);
    idle(); chk("t1_flag1_hold", int'(turn_flag), 3);
    node(); chk("t1_flag2", int'(turn_flag), 0);
    node(); chk("t1_flag3", int'(turn_flag), 2);
    node();
    chk("t1_end_path", int'(end_path), 1);
    chk("t1_end_flag", int'(turn_flag), 0);
    chk("t1_end_count", int'(node_count), 4);
    chk("t1_end_busy", int'(busy), 0);
    node(); chk("done_nc_count", int'(node_count), 4);

    // Restart from DONE, then clear together with a node pulse.
    go();
    chk("rs_end_path", int'(end_path), 0);
    chk("rs_flag", int'(turn_flag), 1);
    cyc(0, 2'd0, 0, 0, 1, 1, 0);
    chk("clr_path_len", int'(path_len), 0);
    chk("clr_count", int'(node_count), 0);
    chk("clr_ready", int'(lif.load_ready), 1);

    // Overflow: five entries without load_last into a 4-deep list.
    ld(2, 0); ld(2, 0); ld(1, 0); ld(3, 0);
    chk("ov_ready_full", int'(lif.load_ready), 0);
    ld(0, 0);
    chk("ov_flag", int'(overflow), 1);
    chk("ov_path_len", int'(path_len), 4);
    cyc(0, 2'd0, 0, 0, 0, 1, 0);
    chk("ov_clr", int'(overflow), 0);

    // Back-to-back node pulses on list 1,2,3.
    ld(1, 0); ld(2, 0); ld(3, 1);
    go(); chk("bb_flag0", int'(turn_flag), 1);
    node(); chk("bb_flag1", int'(turn_flag), 2);
    node(); chk("bb_flag2", int'(turn_flag), 3);
    chk("bb_count", int'(node_count), 2);

    // Reset in the middle of a 4-entry run, then reload.
    cyc(0, 2'd0, 0, 0, 0, 1, 0);
    ld(3, 0); ld(2, 0); ld(1, 0); ld(0, 1);
    go(); node(); node();
    cyc(0, 2'd0, 0, 0, 0, 0, 1);
    chk("mr_flag", int'(turn_flag), 0);
    chk("mr_end", int'(end_path), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_len", int'(path_len), 0);
    chk("mr_ready", int'(lif.load_ready), 1);
    ld(3, 0); ld(1, 1);
    chk("mr_reload_len", int'(path_len), 2);
    go(); chk("mr_reload_flag", int'(turn_flag), 3);
    node(); chk("mr_reload_flag1", int'(turn_flag), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(1, 0), 2'($urandom_range(3, 0)), ($urandom_range(3, 0) == 0),
          ($urandom_range(7, 0) == 0), ($urandom_range(2, 0) == 0),
          ($urandom_range(63, 0) == 0), ($urandom_range(127, 0) == 0));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
